// File: rtl/note_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// note_sequencer_pkg
//   Shared definitions for the note sequencer: FSM state encoding, the bit
//   layout of a pattern entry and the width of the duration field.
//
//   Entry word (MSB first): END | REST | reserved | DUR[4:0] | PITCH.
//   The upper byte is the control byte. The bit positions below are offsets
//   inside that byte, so they do not depend on the pitch width.
// -----------------------------------------------------------------------------
package note_sequencer_pkg;

  localparam int DUR_WIDTH = 5;

  // Positions inside the control byte that sits directly above the pitch field
  localparam int END_BIT  = 7;
  localparam int REST_BIT = 6;
  localparam int RSVD_BIT = 5;
  localparam int DUR_MSB  = 4;
  localparam int DUR_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    LOAD,
    PLAY
  } seq_state_e;

  // The pitch field always starts at bit 0, so its MSB follows from its width
  function automatic int pitchMsb(input int pitchWidth);
    return pitchWidth - 1;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// -----------------------------------------------------------------------------
// note_sequencer_if
//   Groups the two buses the sequencer talks to.
//     Pattern memory : o_rd_en, o_rd_addr -> i_rd_data (1-cycle read latency)
//     Duration ctr   : o_dur_load, o_dur_value -> i_dur_done, i_dur_running
//   master = sequencer side, slave = memory / duration counter side.
// -----------------------------------------------------------------------------
interface note_sequencer_if
  import note_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int PITCH_WIDTH = 8
);

  logic                   o_rd_en;
  logic [ADDR_WIDTH-1:0]  o_rd_addr;
  logic [PITCH_WIDTH+7:0] i_rd_data;
  logic                   o_dur_load;
  logic [DUR_WIDTH-1:0]   o_dur_value;
  logic                   i_dur_done;
  logic                   i_dur_running;

  modport master (
    output o_rd_en, o_rd_addr, o_dur_load, o_dur_value,
    input  i_rd_data, i_dur_done, i_dur_running
  );

  modport slave (
    input  o_rd_en, o_rd_addr, o_dur_load, o_dur_value,
    output i_rd_data, i_dur_done, i_dur_running
  );

endinterface

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//   Walks a pattern of note entries in a synchronous memory. Each entry loads
//   the duration counter, drives pitch/gate to the voice and waits for the
//   counter's done pulse before the next entry is fetched. Supports stop or
//   loop at the END entry, and REST entries (gate low, pitch held).
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_enable         shared tick strobe (same one the duration counter uses)
//   i_start          start pulse, honoured in IDLE only
//   i_stop           abort pulse, overrides everything except reset
//   i_loop           level: restart at i_start_addr on END
//   i_start_addr     start / loop address
//   bus              memory read port and duration counter handshake
//   o_pitch, o_gate  voice outputs
//   o_note_start     1-cycle pulse when a new entry takes effect
//   o_busy           high in every state except IDLE
// -----------------------------------------------------------------------------
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int PITCH_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_loop,
  input  logic [ADDR_WIDTH-1:0]  i_start_addr,
  note_sequencer_if.master       bus,
  output logic [PITCH_WIDTH-1:0] o_pitch,
  output logic                   o_gate,
  output logic                   o_note_start,
  output logic                   o_busy
);

  localparam int PITCH_MSB = pitchMsb(PITCH_WIDTH);

  seq_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   played_q, played_d;
  logic                   rest_q, rest_d;
  logic [DUR_WIDTH-1:0]   dur_q, dur_d;
  logic [PITCH_WIDTH-1:0] entryPitch_q, entryPitch_d;
  logic [PITCH_WIDTH-1:0] pitch_q, pitch_d;
  logic                   gate_q, gate_d;
  logic                   noteStart_q, noteStart_d;
  logic                   rdEn;
  logic                   durLoad;

  logic [7:0]             rdCtrl;
  logic [PITCH_WIDTH-1:0] rdPitch;
  logic                   unusedReserved;

  assign rdCtrl         = bus.i_rd_data[PITCH_WIDTH +: 8];
  assign rdPitch        = bus.i_rd_data[PITCH_MSB:0];
  assign unusedReserved = rdCtrl[RSVD_BIT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      played_q     <= 1'b0;
      rest_q       <= 1'b0;
      dur_q        <= '0;
      entryPitch_q <= '0;
      pitch_q      <= '0;
      gate_q       <= 1'b0;
      noteStart_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      played_q     <= played_d;
      rest_q       <= rest_d;
      dur_q        <= dur_d;
      entryPitch_q <= entryPitch_d;
      pitch_q      <= pitch_d;
      gate_q       <= gate_d;
      noteStart_q  <= noteStart_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    played_d     = played_q;
    rest_d       = rest_q;
    dur_d        = dur_q;
    entryPitch_d = entryPitch_q;
    pitch_d      = pitch_q;
    gate_d       = gate_q;
    noteStart_d  = 1'b0;
    rdEn         = 1'b0;
    durLoad      = 1'b0;

    if (i_stop) begin
      // The duration counter keeps running; the busy wait in LOAD keeps a
      // later restart from consuming its stale done pulse.
      state_d = IDLE;
      gate_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            addr_d   = i_start_addr;
            played_d = 1'b0;
            state_d  = FETCH;
          end
        end
        FETCH: begin
          rdEn    = 1'b1;
          state_d = WAIT_DATA;
        end
        WAIT_DATA: begin
          rest_d       = rdCtrl[REST_BIT];
          dur_d        = rdCtrl[DUR_MSB:DUR_LSB];
          entryPitch_d = rdPitch;
          if (rdCtrl[END_BIT]) begin
            // Looping is only allowed after at least one note has played,
            // otherwise a pattern of bare END entries would spin forever.
            if (i_loop && played_q) begin
              addr_d   = i_start_addr;
              played_d = 1'b0;
              state_d  = FETCH;
            end else begin
              gate_d  = 1'b0;
              state_d = IDLE;
            end
          end else begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (!bus.i_dur_running) begin
            durLoad = 1'b1;
            if (i_enable) begin
              pitch_d     = rest_q ? pitch_q : entryPitch_q;
              gate_d      = !rest_q;
              noteStart_d = 1'b1;
              played_d    = 1'b1;
              addr_d      = addr_q + ADDR_WIDTH'(1);
              state_d     = PLAY;
            end
          end
        end
        PLAY: begin
          // Gate is left untouched so consecutive notes stay legato
          if (bus.i_dur_done) state_d = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.o_rd_en     = rdEn;
  assign bus.o_rd_addr   = addr_q;
  assign bus.o_dur_load  = durLoad;
  assign bus.o_dur_value = durLoad ? dur_q : '0;
  assign o_pitch         = pitch_q;
  assign o_gate          = gate_q;
  assign o_note_start    = noteStart_q;
  assign o_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//   Drives note_sequencer with a behavioural pattern ROM and duration counter.
//   A table of expected note events covers the main pattern; hand-written
//   sequences cover loop, bare END, stop/restart, address wrap and reset.
// -----------------------------------------------------------------------------
module tb_note_sequencer;
  import note_sequencer_pkg::*;

  localparam int AW = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loopEn = 1'b0;
  logic [AW-1:0] startAddr = '0;
  logic [PW-1:0] pitch;
  logic          gate, noteStart, busy;

  int checks = 0;
  int errors = 0;

  note_sequencer_if #(.ADDR_WIDTH(AW), .PITCH_WIDTH(PW)) bus ();

  note_sequencer #(.ADDR_WIDTH(AW), .PITCH_WIDTH(PW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_start     (start),
    .i_stop      (stop),
    .i_loop      (loopEn),
    .i_start_addr(startAddr),
    .bus         (bus),
    .o_pitch     (pitch),
    .o_gate      (gate),
    .o_note_start(noteStart),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // Tick strobe: one cycle in four
  int cycCnt = 0;
  always @(negedge clk) begin
    cycCnt = (cycCnt + 1) % 4;
    enable = (cycCnt == 0);
  end

  // Pattern ROM with one cycle of read latency
  logic [PW+7:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr];
  end

  // Duration counter model: loaded with D on tick T, done fires on tick T+D+1.
  // It has no reset so it keeps running across a sequencer reset or stop.
  logic [4:0] durCnt = '0;
  logic       durRunning = 1'b0;
  logic       durDone = 1'b0;
  int         tickIdx = 0;
  int         lastLoadTick = 0;
  logic [4:0] lastLoadValue = '0;
  int         loadCycles = 0;
  logic       loadWhileRunning = 1'b0;

  always @(posedge clk) begin
    durDone <= 1'b0;
    if (bus.o_dur_load) loadCycles <= loadCycles + 1;
    if (bus.o_dur_load && durRunning) loadWhileRunning <= 1'b1;
    if (enable) begin
      tickIdx <= tickIdx + 1;
      if (bus.o_dur_load) begin
        durCnt        <= bus.o_dur_value;
        durRunning    <= 1'b1;
        lastLoadTick  <= tickIdx;
        lastLoadValue <= bus.o_dur_value;
      end else if (durRunning) begin
        if (durCnt == 5'd0) begin
          durDone    <= 1'b1;
          durRunning <= 1'b0;
        end else begin
          durCnt <= durCnt - 5'd1;
        end
      end
    end
  end

  assign bus.i_dur_done    = durDone;
  assign bus.i_dur_running = durRunning;

  typedef struct {
    logic [7:0] pitch;
    logic       gate;
    logic [4:0] dur;
    int         interval;
    bit         legato;
  } noteVec_t;

  noteVec_t vecs [4];

  function automatic logic [PW+7:0] entry(input bit isEnd, input bit isRest,
                                          input int dur, input int p);
    logic [4:0]    d;
    logic [PW-1:0] pp;
    d  = dur[4:0];
    pp = p[PW-1:0];
    return {isEnd, isRest, 1'b0, d, pp};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic lp);
    @(negedge clk);
    startAddr = addr;
    loopEn    = lp;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic waitNoteStart(input int budget, output bit ok, output int gateLow);
    ok      = 1'b0;
    gateLow = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (noteStart) begin
        ok = 1'b1;
        break;
      end
      if (!gate) gateLow++;
    end
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int gl;
    int prevTick;
    int snap;
    int busyCycles;
    int rdCycles;

    for (int a = 0; a < 256; a++) mem[a] = entry(1, 0, 0, 0);
    mem[8'h00] = entry(0, 0, 2, 8'h40);
    mem[8'h01] = entry(0, 0, 0, 8'h45);
    mem[8'h02] = entry(0, 1, 1, 8'h77);
    mem[8'h03] = entry(0, 0, 3, 8'h50);
    mem[8'h04] = entry(1, 0, 0, 0);
    mem[8'h20] = entry(0, 0, 0, 8'h10);
    mem[8'h21] = entry(1, 0, 0, 0);
    mem[8'h30] = entry(1, 0, 0, 0);
    mem[8'h40] = entry(0, 0, 31, 8'h60);
    mem[8'h41] = entry(0, 0, 0, 8'h61);
    mem[8'h42] = entry(1, 0, 0, 0);
    mem[8'hFF] = entry(0, 0, 0, 8'h70);

    // Interval = ticks since previous load = previous DUR + 2
    vecs[0] = '{pitch: 8'h40, gate: 1'b1, dur: 5'd2, interval: 0, legato: 1'b0};
    vecs[1] = '{pitch: 8'h45, gate: 1'b1, dur: 5'd0, interval: 4, legato: 1'b1};
    vecs[2] = '{pitch: 8'h45, gate: 1'b0, dur: 5'd1, interval: 2, legato: 1'b0};
    vecs[3] = '{pitch: 8'h50, gate: 1'b1, dur: 5'd3, interval: 3, legato: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_voice", {pitch, gate, noteStart, busy}, '0);
    checkOutput("reset_rd", {bus.o_rd_en, bus.o_rd_addr}, '0);
    checkOutput("reset_dur", {bus.o_dur_load, bus.o_dur_value}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("start_stop_same_cycle_busy", busy, 0);

    // Main pattern from the table
    $display("[TB] main pattern");
    applyStimulus(8'h00, 1'b0);
    prevTick = 0;
    for (int i = 0; i < 4; i++) begin
      waitNoteStart(400, ok, gl);
      checkOutput($sformatf("main%0d_seen", i), ok, 1);
      checkOutput($sformatf("main%0d_pitch", i), pitch, vecs[i].pitch);
      checkOutput($sformatf("main%0d_gate", i), gate, vecs[i].gate);
      checkOutput($sformatf("main%0d_dur", i), lastLoadValue, vecs[i].dur);
      if (i > 0)
        checkOutput($sformatf("main%0d_interval", i), lastLoadTick - prevTick,
                    vecs[i].interval);
      if (vecs[i].legato) checkOutput($sformatf("main%0d_legato", i), gl, 0);
      prevTick = lastLoadTick;
    end
    waitIdle(400, ok);
    checkOutput("main_end_idle", ok, 1);
    checkOutput("main_end_gate", gate, 0);

    // Loop a single note
    $display("[TB] loop");
    applyStimulus(8'h20, 1'b1);
    for (int k = 0; k < 3; k++) begin
      waitNoteStart(200, ok, gl);
      checkOutput($sformatf("loop%0d_seen", k), ok, 1);
      checkOutput($sformatf("loop%0d_pitch", k), pitch, 8'h10);
      if (k > 0) checkOutput($sformatf("loop%0d_interval", k), lastLoadTick - prevTick, 3);
      prevTick = lastLoadTick;
    end
    @(negedge clk);
    loopEn = 1'b0;
    waitIdle(200, ok);
    checkOutput("loop_exit_idle", ok, 1);
    checkOutput("loop_exit_gate", gate, 0);

    // Bare END with loop: guard returns to IDLE with no load
    $display("[TB] bare END");
    snap = loadCycles;
    applyStimulus(8'h30, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("bare_end_busy", busy, 0);
    checkOutput("bare_end_no_load", loadCycles - snap, 0);
    loopEn = 1'b0;

    // Stop mid-note, restart while the counter is still running
    $display("[TB] stop and restart");
    applyStimulus(8'h40, 1'b0);
    waitNoteStart(200, ok, gl);
    checkOutput("stop_first_seen", ok, 1);
    prevTick = lastLoadTick;
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("stop_gate", gate, 0);
    checkOutput("stop_busy", busy, 0);
    applyStimulus(8'h40, 1'b0);
    waitNoteStart(400, ok, gl);
    checkOutput("restart_seen", ok, 1);
    checkOutput("restart_pitch", pitch, 8'h60);
    checkOutput("restart_interval", lastLoadTick - prevTick, 33);
    checkOutput("restart_no_early_load", loadWhileRunning, 0);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int c = 0; c < 300 && durRunning; c++) @(negedge clk);

    // Address wrap from 0xFF to 0x00
    $display("[TB] wrap");
    applyStimulus(8'hFF, 1'b0);
    waitNoteStart(200, ok, gl);
    checkOutput("wrap_first_pitch", pitch, 8'h70);
    waitNoteStart(200, ok, gl);
    checkOutput("wrap_second_seen", ok, 1);
    checkOutput("wrap_second_pitch", pitch, 8'h40);
    waitIdle(600, ok);
    checkOutput("wrap_end_idle", ok, 1);

    // Asynchronous reset mid-note, then a stale done must be ignored
    $display("[TB] reset mid-note");
    applyStimulus(8'h40, 1'b0);
    waitNoteStart(200, ok, gl);
    checkOutput("rst_note_seen", ok, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_voice", {pitch, gate, noteStart, busy}, '0);
    checkOutput("async_rst_bus", {bus.o_rd_en, bus.o_rd_addr, bus.o_dur_load}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    busyCycles = 0;
    rdCycles   = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (bus.o_rd_en) rdCycles++;
    end
    checkOutput("post_rst_busy", busyCycles, 0);
    checkOutput("post_rst_no_fetch", rdCycles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
